// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_pkg;

    localparam int WORD_W       = 32;
    localparam int ROW_W        = 128;
    localparam int MATRIX_BEATS = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_bank.sv
// Word-wide single-port synchronous RAM with byte write enables; contents are not reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Read returns the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Services scalar byte/half/word and 128-bit matrix row load/stores over a word-wide bank,
// one response per accepted request.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_matrix,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [ROW_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [ROW_W-1:0]  rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e              state_q, state_d;
    logic [2:0]          wait_cnt_q, wait_cnt_d;
    logic [1:0]          beat_cnt_q, beat_cnt_d;
    logic                write_q, write_d, matrix_q, matrix_d, err_q, err_d;
    logic [1:0]          size_q, size_d;
    logic [AW+1:0]       addr_q, addr_d;
    logic [ROW_W-1:0]    wdata_q, wdata_d;
    logic [95:0]         asm_q, asm_d;
    logic [ROW_W-1:0]    rdata_q, rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                accept, last_beat, req_err;
    logic [30:0]         last_word;
    logic [ROW_W-1:0]    live_rdata;
    logic                bank_en;
    logic [3:0]          bank_be;
    logic [AW-1:0]       bank_addr;
    logic [WORD_W-1:0]   bank_wdata, bank_rdata;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign last_beat = beat_cnt_q == (matrix_q ? 2'(MATRIX_BEATS - 1) : 2'd0);

    // 31-bit sum so a top-of-address-space request cannot wrap back into range.
    assign last_word = {1'b0, req_addr[31:2]} + (req_matrix ? 31'(MATRIX_BEATS - 1) : 31'd0);
    assign req_err   = (req_matrix ? (req_addr[1:0] != 2'b00)
                                   : ((req_size == SZ_H) && req_addr[0])
                                     || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
                                     || (req_size == 2'b11))
                       || (last_word >= 31'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BEAT;
            ST_WAIT: if (wait_cnt_q == 3'(WAIT_CYCLES - 1)) state_d = ST_BEAT;
            ST_BEAT: if (last_beat) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Last beat's word comes straight from the bank in RESP; earlier beats sit in asm_q.
    always_comb begin
        live_rdata = '0;
        if (!err_q && !write_q) begin
            if (matrix_q) live_rdata = {bank_rdata, asm_q};
            else          live_rdata = {96'b0, bank_rdata >> {addr_q[1:0], 3'b000}};
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = (state_q == ST_RESP) ? live_rdata : rdata_q;
        rsp_err   = rsp_err_q;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        write_d    = write_q;
        matrix_d   = matrix_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        asm_d      = asm_q;
        rdata_d    = rdata_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            write_d    = req_write;
            matrix_d   = req_matrix;
            size_d     = req_size;
            addr_d     = req_addr[AW+1:0];
            wdata_d    = req_wdata;
            err_d      = req_err;
            wait_cnt_d = '0;
            beat_cnt_d = '0;
        end
        if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 3'd1;
        if (state_q == ST_BEAT) begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            for (int i = 0; i < MATRIX_BEATS - 1; i++) begin
                if (beat_cnt_q == 2'(i + 1)) asm_d[WORD_W*i +: WORD_W] = bank_rdata;
            end
            if (last_beat) rsp_err_d = err_q;
        end
        if (state_q == ST_RESP) rdata_d = live_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            write_q    <= 1'b0;
            matrix_q   <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            asm_q      <= '0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            write_q    <= write_d;
            matrix_q   <= matrix_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            asm_q      <= asm_d;
            rdata_q    <= rdata_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bank_en   = (state_q == ST_BEAT);
    assign bank_addr = addr_q[AW+1:2] + AW'(beat_cnt_q);

    always_comb begin
        bank_be    = 4'b0000;
        bank_wdata = wdata_q[WORD_W-1:0];
        if (matrix_q) begin
            for (int i = 0; i < MATRIX_BEATS; i++) begin
                if (beat_cnt_q == 2'(i)) bank_wdata = wdata_q[WORD_W*i +: WORD_W];
            end
            bank_be = 4'b1111;
        end else begin
            case (size_q)
                SZ_B: begin
                    bank_be    = 4'b0001 << addr_q[1:0];
                    bank_wdata = {4{wdata_q[7:0]}};
                end
                SZ_H: begin
                    bank_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    bank_wdata = {2{wdata_q[15:0]}};
                end
                SZ_W:    bank_be = 4'b1111;
                default: bank_be = 4'b0000;
            endcase
        end
        if (!write_q || err_q || (state_q != ST_BEAT)) bank_be = 4'b0000;
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances against a byte-array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         v [2], rdy [2], w [2], m [2], rv [2], re [2];
    logic [1:0]   sz [2];
    logic [31:0]  a [2];
    logic [127:0] wd [2], rd [2];

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_b [2][DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(rdy[0]), .req_write(w[0]),
        .req_matrix(m[0]), .req_size(sz[0]), .req_addr(a[0]), .req_wdata(wd[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(rdy[1]), .req_write(w[1]),
        .req_matrix(m[1]), .req_size(sz[1]), .req_addr(a[1]), .req_wdata(wd[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));

    // Byte-level reference: applies a request to mem_b and returns the expected response.
    task automatic model_exec(input int d, input bit wr, input bit mx, input bit [1:0] s,
                              input bit [31:0] ad, input bit [127:0] wdat,
                              output bit [127:0] er, output bit ee);
        int nb, al;
        longint lastw;
        nb    = mx ? 16 : (s == 2'd0 ? 1 : (s == 2'd1 ? 2 : 4));
        al    = mx ? 4 : nb;
        lastw = longint'(ad >> 2) + (mx ? 3 : 0);
        ee    = (!mx && s == 2'b11) || ((ad % 32'(al)) != 0) || (lastw >= DEPTH);
        er    = '0;
        if (ee) return;
        if (wr) begin
            for (int k = 0; k < nb; k++) mem_b[d][int'(ad) + k] = wdat[8*k +: 8];
        end else if (mx) begin
            for (int k = 0; k < 16; k++) er[8*k +: 8] = mem_b[d][int'(ad) + k];
        end else begin
            for (int k = 0; k < 4 - int'(ad % 4); k++) er[8*k +: 8] = mem_b[d][int'(ad) + k];
        end
    endtask

    task automatic do_req(input int d, input bit wr, input bit mx, input bit [1:0] s,
                          input bit [31:0] ad, input bit [127:0] wdat, input string tag,
                          output bit [127:0] got, output bit gerr);
        bit [127:0] er;
        bit ee;
        int lat, exp_lat;
        model_exec(d, wr, mx, s, ad, wdat, er, ee);
        exp_lat = (d == 0 ? 1 : 0) + (mx ? 4 : 1);
        @(negedge clk);
        total++;
        if (rdy[d] !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", tag, rdy[d]); end
        v[d] = 1'b1; w[d] = wr; m[d] = mx; sz[d] = s; a[d] = ad; wd[d] = wdat;
        @(posedge clk); #1;
        v[d] = 1'b0; a[d] = $urandom; wd[d] = {4{$urandom}}; w[d] = 1'b1;
        total++;
        if (rdy[d] !== 1'b0) begin bad++; $display("FAIL %s ready_busy: got %b want 0", tag, rdy[d]); end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rv[d] === 1'b1) begin lat = k; break; end
        end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
        got = rd[d]; gerr = re[d];
        if (lat != 0) begin
            total++;
            if (rd[d] !== er) begin bad++; $display("FAIL %s rdata: got %h want %h", tag, rd[d], er); end
            total++;
            if (re[d] !== ee) begin bad++; $display("FAIL %s err: got %b want %b", tag, re[d], ee); end
            total++;
            if (rdy[d] !== 1'b0) begin bad++; $display("FAIL %s ready_resp: got %b want 0", tag, rdy[d]); end
        end
        @(posedge clk); #1;
        total++;
        if (rv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
            bad++; $display("FAIL %s after_resp: valid=%b ready=%b want 0/1", tag, rv[d], rdy[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdy[d] !== 1'b1 || rv[d] !== 1'b0 || rd[d] !== '0 || re[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b err=%b rdata=%h want 1/0/0/0",
                         d, rdy[d], rv[d], re[d], rd[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic prefill();
        bit [127:0] g;
        bit ge;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) do_req(d, 1, 0, 2'd2, 32'(4*i), {96'b0, $urandom}, "prefill", g, ge);
            for (int i = DEPTH-4; i < DEPTH; i++) do_req(d, 1, 0, 2'd2, 32'(4*i), {96'b0, $urandom}, "prefill", g, ge);
        end
    endtask

    task automatic test_word();
        bit [127:0] g;
        bit ge;
        do_req(0, 1, 0, 2'd2, 32'h10, 128'hDEADBEEF, "word_store", g, ge);
        do_req(0, 0, 0, 2'd2, 32'h10, '0, "word_load", g, ge);
        total++;
        if (g !== 128'hDEADBEEF) begin bad++; $display("FAIL word_const: got %h want deadbeef", g); end
    endtask

    task automatic test_lanes();
        bit [127:0] g;
        bit ge;
        do_req(0, 1, 0, 2'd2, 32'h20, 128'h11223344, "lane_word", g, ge);
        do_req(0, 1, 0, 2'd0, 32'h22, 128'hAA, "lane_byte", g, ge);
        do_req(0, 1, 0, 2'd1, 32'h20, 128'h5566, "lane_half", g, ge);
        do_req(0, 0, 0, 2'd2, 32'h20, '0, "lane_load", g, ge);
        total++;
        if (g !== 128'h11AA5566) begin bad++; $display("FAIL lane_const: got %h want 11aa5566", g); end
        do_req(0, 0, 0, 2'd0, 32'h23, '0, "lane_byte_load", g, ge);
        total++;
        if (g !== 128'h11) begin bad++; $display("FAIL byte_const: got %h want 11", g); end
    endtask

    task automatic test_matrix();
        bit [127:0] g;
        bit ge;
        bit [127:0] row;
        row = 128'h00000004_00000003_00000002_00000001;
        do_req(0, 1, 1, 2'd0, 32'h40, row, "mst", g, ge);
        do_req(0, 0, 1, 2'd0, 32'h40, '0, "mvtr", g, ge);
        total++;
        if (g !== row) begin bad++; $display("FAIL mvtr_const: got %h want %h", g, row); end
        do_req(0, 0, 0, 2'd2, 32'h48, '0, "mst_word2", g, ge);
        total++;
        if (g !== 128'h3) begin bad++; $display("FAIL mst_word2_const: got %h want 3", g); end
    endtask

    task automatic test_errors();
        bit [127:0] g;
        bit ge;
        do_req(0, 1, 0, 2'd1, 32'h31, 128'hBEEF, "err_half", g, ge);
        total++;
        if (ge !== 1'b1 || g !== '0) begin bad++; $display("FAIL err_half_const: err=%b rdata=%h want 1/0", ge, g); end
        do_req(0, 1, 0, 2'd3, 32'h30, 128'hCAFEF00D, "err_size", g, ge);
        total++;
        if (ge !== 1'b1) begin bad++; $display("FAIL err_size_const: got %b want 1", ge); end
        do_req(0, 0, 0, 2'd2, 32'h30, '0, "err_unchanged", g, ge);
        do_req(0, 1, 1, 2'd0, 32'(4*(DEPTH-2)), {4{32'h5A5A5A5A}}, "err_matrix_oob", g, ge);
        total++;
        if (ge !== 1'b1 || g !== '0) begin bad++; $display("FAIL err_oob_const: err=%b rdata=%h want 1/0", ge, g); end
        do_req(0, 0, 0, 2'd2, 32'(4*(DEPTH-2)), '0, "oob_unchanged0", g, ge);
        do_req(0, 0, 0, 2'd2, 32'(4*(DEPTH-1)), '0, "oob_unchanged1", g, ge);
        do_req(0, 0, 0, 2'd2, 32'h0000_0000, '0, "wrap_unchanged", g, ge);
        do_req(0, 0, 0, 2'd0, 32'(4*DEPTH), '0, "err_scalar_oob", g, ge);
        do_req(0, 0, 1, 2'd0, 32'hFFFF_FFF0, '0, "err_top_addr", g, ge);
        do_req(0, 0, 1, 2'd0, 32'(4*(DEPTH-4)), '0, "matrix_top_ok", g, ge);
    endtask

    task automatic test_wait0();
        bit [127:0] g;
        bit ge;
        do_req(1, 1, 0, 2'd2, 32'h8, 128'h01234567, "w0_store", g, ge);
        do_req(1, 0, 0, 2'd1, 32'hA, '0, "w0_load", g, ge);
        total++;
        if (g !== 128'h0123) begin bad++; $display("FAIL w0_const: got %h want 0123", g); end
        do_req(1, 1, 1, 2'd0, 32'h60, {$urandom, $urandom, $urandom, $urandom}, "w0_mst", g, ge);
        do_req(1, 0, 1, 2'd0, 32'h60, '0, "w0_mvtr", g, ge);
    endtask

    task automatic test_back_to_back();
        bit [127:0] eq_d [$];
        bit         eq_e [$];
        bit [127:0] er;
        bit ee, exp_rv, exp_rdy;
        bit [1:0] s;
        bit [31:0] ad;
        int last_acc, nacc;
        last_acc = -100;
        nacc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            exp_rv  = (cyc - last_acc == 3);
            exp_rdy = (cyc - last_acc >= 4);
            total++;
            if (rv[0] !== exp_rv) begin bad++; $display("FAIL b2b_valid cyc%0d: got %b want %b", cyc, rv[0], exp_rv); end
            total++;
            if (rdy[0] !== exp_rdy) begin bad++; $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc, rdy[0], exp_rdy); end
            if (exp_rv && eq_d.size() > 0) begin
                er = eq_d.pop_front();
                ee = eq_e.pop_front();
                total++;
                if (rd[0] !== er || re[0] !== ee) begin
                    bad++; $display("FAIL b2b_rsp cyc%0d: got %h/%b want %h/%b", cyc, rd[0], re[0], er, ee);
                end
            end
            s  = 2'($urandom_range(0, 2));
            ad = 32'(4*$urandom_range(0, 63) + $urandom_range(0, 3));
            v[0] = (cyc < 48); w[0] = 1'($urandom_range(0, 1)); m[0] = 1'b0; sz[0] = s;
            a[0] = ad; wd[0] = {$urandom, $urandom, $urandom, $urandom};
            if (v[0] && exp_rdy) begin
                model_exec(0, w[0], 1'b0, s, ad, wd[0], er, ee);
                eq_d.push_back(er);
                eq_e.push_back(ee);
                last_acc = cyc;
                nacc++;
            end
        end
        v[0] = 1'b0;
        total++;
        if (eq_d.size() != 0 || nacc < 10) begin
            bad++; $display("FAIL b2b_count: pending=%0d accepted=%0d want 0/>=10", eq_d.size(), nacc);
        end
    endtask

    task automatic test_random();
        bit [127:0] g;
        bit ge, wr, mx;
        bit [1:0] s;
        bit [31:0] ad;
        int d, lane;
        for (int i = 0; i < 150; i++) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            mx = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            lane = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) lane = mx ? 0 : (s == 2'd1 ? (lane & 2) : (s == 2'd0 ? lane : 0));
            ad = mx ? 32'(4*$urandom_range(0, 60) + lane) : 32'(4*$urandom_range(0, 63) + lane);
            if ($urandom_range(0, 9) == 0) ad = 32'(4*$urandom_range(DEPTH-4, DEPTH+2));
            do_req(d, wr, mx, s, ad, {$urandom, $urandom, $urandom, $urandom}, "random", g, ge);
        end
    endtask

    task automatic test_reset_mid();
        bit [127:0] g, row;
        bit ge;
        bit [31:0] old2, old3;
        row  = {$urandom, $urandom, $urandom, $urandom};
        old2 = {mem_b[0][32'h8B], mem_b[0][32'h8A], mem_b[0][32'h89], mem_b[0][32'h88]};
        old3 = {mem_b[0][32'h8F], mem_b[0][32'h8E], mem_b[0][32'h8D], mem_b[0][32'h8C]};
        @(negedge clk);
        v[0] = 1'b1; w[0] = 1'b1; m[0] = 1'b1; sz[0] = 2'd0; a[0] = 32'h80; wd[0] = row;
        @(posedge clk); #1;
        v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (rdy[0] !== 1'b1 || rv[0] !== 1'b0 || rd[0] !== '0 || re[0] !== 1'b0) begin
            bad++; $display("FAIL mid_reset: ready=%b valid=%b err=%b rdata=%h want 1/0/0/0", rdy[0], rv[0], re[0], rd[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) mem_b[0][32'h80 + k] = row[8*k +: 8];
        do_req(0, 0, 0, 2'd2, 32'h80, '0, "mid_beat0", g, ge);
        total++;
        if (g !== {96'b0, row[31:0]}) begin bad++; $display("FAIL mid_beat0_const: got %h want %h", g, row[31:0]); end
        do_req(0, 0, 0, 2'd2, 32'h84, '0, "mid_beat1", g, ge);
        do_req(0, 0, 0, 2'd2, 32'h88, '0, "mid_beat2", g, ge);
        total++;
        if (g !== {96'b0, old2}) begin bad++; $display("FAIL mid_beat2_old: got %h want %h", g, old2); end
        do_req(0, 0, 0, 2'd2, 32'h8C, '0, "mid_beat3", g, ge);
        total++;
        if (g !== {96'b0, old3}) begin bad++; $display("FAIL mid_beat3_old: got %h want %h", g, old3); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0; w[d] = 1'b0; m[d] = 1'b0; sz[d] = 2'd0; a[d] = '0; wd[d] = '0;
        end
        test_reset();
        prefill();
        test_word();
        test_lanes();
        test_matrix();
        test_errors();
        test_wait0();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for MEM-stage load/store requests, including matrix row transfers.
- The MEM stage initiates each request through a valid/ready handshake.
- The block services scalar byte/half/word accesses and 128-bit matrix row moves (mst/mvtr) over a word-wide RAM bank.
- Matrix rows transfer as 4 sequential word beats; the block returns one response per request.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the bank.
- WAIT_CYCLES, 1, access wait states inserted before the first beat (legal range 0..7).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_matrix  in  1  1 = 128-bit matrix row access (4 beats), 0 = scalar.
- req_size  in  2  scalar size: 00 byte, 01 half, 10 word; 11 is illegal.
- req_addr  in  32  byte address.
- req_wdata  in  128  store data; scalar uses [31:0]; matrix beat i uses [32i+31:32i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  128  load data.
- rsp_err  out  1  request rejected, qualified by rsp_valid.

Behaviour:
- Reset state: FSM in IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; beat and wait counters at 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, BEAT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, matrix, size, addr and wdata.
  - Go to WAIT if WAIT_CYCLES>0, else to BEAT.
  - req_ready=0 in every other state; req_* inputs are ignored outside IDLE.
- WAIT: stays WAIT_CYCLES cycles, then moves to BEAT.
- BEAT:
  - One cycle per beat; scalar n=1, matrix n=4.
  - Beat i accesses word index addr[31:2]+i.
  - After the last beat, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. A new request is accepted no earlier than the next IDLE cycle.
- Latency: rsp_valid rises WAIT_CYCLES+n rising edges after the accepting edge.
  - WAIT_CYCLES=1: scalar = 2, matrix = 5.
  - Back-to-back throughput is one request per WAIT_CYCLES+n+2 cycles.
- Error check is made once, at accept time. A request is in error if any of the following holds:
  - scalar half with addr[0]=1;
  - scalar word with addr[1:0]!=0;
  - matrix with addr[1:0]!=0;
  - req_size=11 on a scalar request;
  - addr[31:2]+n-1 >= DEPTH_WORDS, computed without wrap using a 31-bit sum.
- An errored request still runs WAIT/BEAT timing but performs no RAM writes. Its response has rsp_err=1 and rsp_rdata=0.
- Scalar stores:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all 4 lanes.
  - Other lanes are unchanged.
- Scalar loads: rsp_rdata = {96'b0, word >> (8*addr[1:0])}, raw and unmasked above the access size. Sign/zero extension belongs to the MEM stage.
- Matrix loads: rsp_rdata[32i+31:32i] = word(base+i).
- Matrix stores: beat i writes word(base+i) with the full word.
- Stores get rsp_rdata=0 in the response.
- RAM read is synchronous: beat read data is captured into an internal 128-bit assembly register on the edge after the beat's address is presented. The RESP cycle covers the last capture.
- rsp_rdata and rsp_err hold their values until the next RESP; they are only meaningful while rsp_valid=1.
- Reset asserted mid-operation: FSM returns to IDLE immediately and no response is issued. Matrix-store beats already written stay written.

Decomposition:
- Package dmem_pkg holds:
  - size codes SZ_B/SZ_H/SZ_W;
  - FSM state enum;
  - MATRIX_BEATS=4;
  - WORD_W=32, ROW_W=128.
- Sub-module dmem_bank: DEPTH_WORDS x 32 synchronous RAM with 4-bit byte-write enable, one read/write port, no reset.

Test Plan:
1. Word store then load, WAIT_CYCLES=1:
   - store addr 0x10, wdata 0xDEADBEEF -> rsp_valid 2 edges after accept, rsp_err=0;
   - load addr 0x10 -> rsp_rdata[31:0]=0xDEADBEEF, upper 96 bits 0.
2. Byte/half lanes:
   - word 0x20 = 0x11223344; store byte 0xAA at 0x22; store half 0x5566 at 0x20;
   - word load 0x20 -> 0x11AA5566; byte load at 0x23 -> rsp_rdata=0x11.
3. Matrix round trip:
   - mst addr 0x40, wdata 0x00000004_00000003_00000002_00000001 -> words 0x40..0x4C = 1,2,3,4, rsp at 5 edges;
   - mvtr 0x40 -> identical 128-bit value.
4. Errors, each giving rsp_err=1, rsp_rdata=0 and RAM unchanged:
   - half store at 0x31;
   - req_size=11;
   - matrix at addr 4*(DEPTH_WORDS-2).
5. Handshake:
   - req_valid held high continuously with changing data -> req_ready=0 from WAIT through RESP;
   - exactly one response per acceptance; with WAIT_CYCLES=0, scalar latency is 1 edge.
6. Reset mid-matrix-store:
   - assert rst during beat 2 -> req_ready=1 and rsp_valid=0 immediately;
   - words for beats 0-1 hold the new data, words for beats 2-3 hold the old data.
